// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: arbitrates the Fetch and Memory stages onto the single shared IO
// bus, sequences each transfer through the rd_valid / tx_done handshakes with a
// bounded wait, and produces the pipeline stall signals.
module io_bus_ctrl #(
    parameter int DATAW   = 32,
    parameter int ADDRW   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [ADDRW-1:0] if_addr,
    output logic             if_valid,
    output logic [DATAW-1:0] if_data,
    input  logic             mem_req,
    input  logic             mem_wr,
    input  logic [ADDRW-1:0] mem_addr,
    input  logic [DATAW-1:0] mem_wdata,
    output logic             mem_done,
    output logic [DATAW-1:0] mem_rdata,
    output logic             bus_err,
    output logic             stall_if,
    output logic             stall_mem,
    input  logic             dma_ready,
    input  logic             rd_valid,
    input  logic             tx_done,
    input  logic [DATAW-1:0] cpu_in,
    output logic [DATAW-1:0] cpu_out,
    output logic [ADDRW-1:0] cpu_addr,
    output logic [1:0]       op
);

    localparam int              CNTW     = $clog2(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [1:0]      OP_NOP   = 2'b00;
    localparam logic [1:0]      OP_READ  = 2'b01;
    localparam logic [1:0]      OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNTW-1:0]  cnt_r;
    logic             gnt_mem_r;
    logic             grant_s;
    logic             done_s;
    logic             abort_s;
    logic             waiting_s;
    logic [1:0]       op_next_s;
    logic [1:0]       op_r;
    logic [ADDRW-1:0] cpu_addr_r;
    logic [DATAW-1:0] cpu_out_r;
    logic [DATAW-1:0] if_data_r;
    logic [DATAW-1:0] mem_rdata_r;
    logic             if_valid_r;
    logic             mem_done_r;
    logic             bus_err_r;

    // Next-state logic: grant in IDLE (Memory first), finish on handshake or wait expiry.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        waiting_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dma_ready && (mem_req || if_req)) begin
                    grant_s = 1'b1;
                    if (mem_req) begin
                        if (mem_wr) begin
                            state_next_s = ST_MEM_WR;
                        end else begin
                            state_next_s = ST_MEM_RD;
                        end
                    end else begin
                        state_next_s = ST_IF_RD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                waiting_s = 1'b1;
                if (rd_valid) begin
                    done_s       = 1'b1;
                    state_next_s = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_MEM_WR: begin
                waiting_s = 1'b1;
                if (tx_done) begin
                    done_s       = 1'b1;
                    state_next_s = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Bus opcode follows the state being entered so op is registered with it.
    always_comb begin
        op_next_s = OP_NOP;
        case (state_next_s)
            ST_IF_RD, ST_MEM_RD: op_next_s = OP_READ;
            ST_MEM_WR:           op_next_s = OP_WRITE;
            default:             op_next_s = OP_NOP;
        endcase
    end

    // State and opcode registers; reset drops op to NOP immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NOP;
        end else begin
            state_r <= state_next_s;
            op_r    <= op_next_s;
        end
    end

    // Wait counter: cleared on grant, advances every cycle spent waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (grant_s) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (waiting_s) begin
            cnt_r <= cnt_r + CNTW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Register the granted requester, address and write data at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_mem_r  <= 1'b0;
            cpu_addr_r <= {ADDRW{1'b0}};
            cpu_out_r  <= {DATAW{1'b0}};
        end else if (grant_s) begin
            gnt_mem_r  <= mem_req;
            cpu_addr_r <= mem_req ? mem_addr : if_addr;
            cpu_out_r  <= (mem_req && mem_wr) ? mem_wdata : cpu_out_r;
        end else begin
            gnt_mem_r  <= gnt_mem_r;
            cpu_addr_r <= cpu_addr_r;
            cpu_out_r  <= cpu_out_r;
        end
    end

    // One-cycle response pulses, asserted for the whole RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_r <= 1'b0;
            mem_done_r <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            if_valid_r <= (done_s || abort_s) && !gnt_mem_r;
            mem_done_r <= (done_s || abort_s) && gnt_mem_r;
            bus_err_r  <= abort_s;
        end
    end

    // Capture read data on completion; an aborted read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_data_r   <= {DATAW{1'b0}};
            mem_rdata_r <= {DATAW{1'b0}};
        end else if (state_r == ST_IF_RD) begin
            if_data_r   <= done_s ? cpu_in : (abort_s ? {DATAW{1'b0}} : if_data_r);
            mem_rdata_r <= mem_rdata_r;
        end else if (state_r == ST_MEM_RD) begin
            if_data_r   <= if_data_r;
            mem_rdata_r <= done_s ? cpu_in : (abort_s ? {DATAW{1'b0}} : mem_rdata_r);
        end else begin
            if_data_r   <= if_data_r;
            mem_rdata_r <= mem_rdata_r;
        end
    end

    assign op        = op_r;
    assign cpu_addr  = cpu_addr_r;
    assign cpu_out   = cpu_out_r;
    assign if_valid  = if_valid_r;
    assign if_data   = if_data_r;
    assign mem_done  = mem_done_r;
    assign mem_rdata = mem_rdata_r;
    assign bus_err   = bus_err_r;
    assign stall_if  = if_req & ~if_valid_r;
    assign stall_mem = mem_req & ~mem_done_r;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed scenarios followed by randomized
// transactions checked against a transaction-level reference model.
module tb_io_bus_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, mem_req, mem_wr, dma_ready, rd_valid, tx_done;
    logic [AW-1:0] if_addr, mem_addr, cpu_addr;
    logic [DW-1:0] mem_wdata, cpu_in, cpu_out, if_data, mem_rdata;
    logic          if_valid, mem_done, bus_err, stall_if, stall_mem;
    logic [1:0]    op;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [31:0]   exp_if_data   = 32'h0;
    logic [31:0]   exp_mem_rdata = 32'h0;

    io_bus_ctrl #(.DATAW(DW), .ADDRW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .bus_err(bus_err),
        .stall_if(stall_if), .stall_mem(stall_mem), .dma_ready(dma_ready),
        .rd_valid(rd_valid), .tx_done(tx_done), .cpu_in(cpu_in), .cpu_out(cpu_out),
        .cpu_addr(cpu_addr), .op(op)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completion wait index: < TO completes in that wait cycle, >= TO never completes.
    function automatic int pick_k(input int t);
        if (t == 0) return TO - 1;
        if (t == 1) return TO;
        return int'($urandom_range(0, TO + 1));
    endfunction

    // One transfer for a requester already asserting its request.
    task automatic run_xfer(input bit is_mem, input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int k);
        int          n;
        bit          granted;
        bit          fin;
        bit          abort;
        logic [31:0] rd;
        logic [1:0]  exp_op;
        exp_op  = is_wr ? 2'b10 : 2'b01;
        granted = 1'b0;
        n       = 0;
        while (!granted && n < 8) begin
            step();
            n++;
            if (op !== 2'b00) granted = 1'b1;
        end
        chk_bit("grant_seen", granted, 1'b1);
        if (!granted) return;
        chk32("xfer_op", 32'(op), 32'(exp_op));
        chk32("xfer_addr", cpu_addr, addr);
        if (is_wr) chk32("xfer_wdata", cpu_out, wdata);
        if (is_mem) begin
            mem_addr  = $urandom;
            mem_wdata = $urandom;
        end else begin
            if_addr = $urandom;
        end
        fin = 1'b0;
        for (int idx = 0; idx < TO && !fin; idx++) begin
            rd        = $urandom;
            cpu_in    = rd;
            dma_ready = 1'($urandom_range(0, 1));
            if (is_wr) begin
                tx_done  = (idx == k);
                rd_valid = 1'b1;
            end else begin
                rd_valid = (idx == k);
                tx_done  = 1'b1;
            end
            step();
            rd_valid  = 1'b0;
            tx_done   = 1'b0;
            dma_ready = 1'b1;
            abort     = 1'b0;
            if (idx == k || idx == TO - 1) begin
                fin   = 1'b1;
                abort = (idx != k);
                if (!is_wr) begin
                    if (is_mem) exp_mem_rdata = abort ? 32'h0 : rd;
                    else        exp_if_data   = abort ? 32'h0 : rd;
                end
            end
            chk_bit("if_valid", if_valid, fin && !is_mem);
            chk_bit("mem_done", mem_done, fin && is_mem);
            chk_bit("bus_err", bus_err, abort);
            chk_bit("stall_if", stall_if, if_req && !(fin && !is_mem));
            chk_bit("stall_mem", stall_mem, mem_req && !(fin && is_mem));
            chk32("op_wait", 32'(op), fin ? 32'h0 : 32'(exp_op));
            chk32("if_data", if_data, exp_if_data);
            chk32("mem_rdata", mem_rdata, exp_mem_rdata);
        end
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; dma_ready = 1'b0;
        rd_valid = 1'b0; tx_done = 1'b0; if_addr = 32'h0; mem_addr = 32'h0;
        mem_wdata = 32'h0; cpu_in = 32'h0;
        #1;
        // Reset state
        chk32("rst_op", 32'(op), 32'h0);
        chk32("rst_addr", cpu_addr, 32'h0);
        chk32("rst_out", cpu_out, 32'h0);
        chk32("rst_if_data", if_data, 32'h0);
        chk32("rst_mem_rdata", mem_rdata, 32'h0);
        chk_bit("rst_if_valid", if_valid, 1'b0);
        chk_bit("rst_mem_done", mem_done, 1'b0);
        chk_bit("rst_bus_err", bus_err, 1'b0);
        if_req = 1'b1;
        #1;
        chk_bit("rst_stall_if_comb", stall_if, 1'b1);
        if_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Single fetch
        if_req = 1'b1; if_addr = 32'h100; dma_ready = 1'b1;
        step();
        chk32("fetch_op", 32'(op), 32'h1);
        chk32("fetch_addr", cpu_addr, 32'h100);
        chk_bit("fetch_stall_wait", stall_if, 1'b1);
        rd_valid = 1'b1; cpu_in = 32'hDEADBEEF;
        step();
        rd_valid = 1'b0;
        exp_if_data = 32'hDEADBEEF;
        chk_bit("fetch_valid", if_valid, 1'b1);
        chk32("fetch_data", if_data, 32'hDEADBEEF);
        chk_bit("fetch_stall_drop", stall_if, 1'b0);
        chk32("fetch_op_resp", 32'(op), 32'h0);
        chk_bit("fetch_no_err", bus_err, 1'b0);
        if_req = 1'b0;
        step();
        chk_bit("fetch_pulse_once", if_valid, 1'b0);

        // Collision: Memory write served before Fetch read
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h55;
        run_xfer(1'b1, 1'b1, 32'h20, 32'h55, 0);
        run_xfer(1'b0, 1'b0, 32'h200, 32'h0, 1);
        step();

        // dma_ready low holds off the grant
        dma_ready = 1'b0; mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h44;
        for (int i = 0; i < 5; i++) begin
            step();
            chk32("dma_op_idle", 32'(op), 32'h0);
            chk_bit("dma_stall_mem", stall_mem, 1'b1);
        end
        dma_ready = 1'b1;
        step();
        chk32("dma_grant_op", 32'(op), 32'h1);
        chk32("dma_grant_addr", cpu_addr, 32'h44);
        rd_valid = 1'b1; cpu_in = 32'h12345678;
        step();
        rd_valid = 1'b0;
        exp_mem_rdata = 32'h12345678;
        chk_bit("dma_done", mem_done, 1'b1);
        chk32("dma_rdata", mem_rdata, 32'h12345678);
        mem_req = 1'b0;
        step();

        // Timeout on a read with tx_done asserted (ignored)
        mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h88;
        run_xfer(1'b1, 1'b0, 32'h88, 32'h0, TO);
        step();

        // Held request: no re-grant during RESP, re-served from IDLE
        mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h300;
        step();
        rd_valid = 1'b1; cpu_in = 32'hCAFE;
        step();
        rd_valid = 1'b0;
        exp_mem_rdata = 32'hCAFE;
        chk_bit("held_done", mem_done, 1'b1);
        step();
        chk32("held_no_regrant", 32'(op), 32'h0);
        chk_bit("held_done_once", mem_done, 1'b0);
        chk_bit("held_stall", stall_mem, 1'b1);
        step();
        chk32("held_second_op", 32'(op), 32'h1);
        rd_valid = 1'b1; cpu_in = 32'hBEEF;
        step();
        rd_valid = 1'b0;
        exp_mem_rdata = 32'hBEEF;
        chk_bit("held_second_done", mem_done, 1'b1);
        chk32("held_second_data", mem_rdata, 32'hBEEF);
        mem_req = 1'b0;
        step();

        // Asynchronous reset in the middle of a write
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h77;
        step();
        chk32("rstw_op_write", 32'(op), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk32("rstw_op_async", 32'(op), 32'h0);
        mem_req = 1'b0; tx_done = 1'b1;
        step();
        chk_bit("rstw_no_done", mem_done, 1'b0);
        tx_done = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_if_data = 32'h0; exp_mem_rdata = 32'h0;
        chk_bit("rstw_no_done_after", mem_done, 1'b0);
        chk32("rstw_op", 32'(op), 32'h0);
        chk32("rstw_addr", cpu_addr, 32'h0);
        chk32("rstw_out", cpu_out, 32'h0);
        chk32("rstw_if_data", if_data, 32'h0);
        chk32("rstw_mem_rdata", mem_rdata, 32'h0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 30; t++) begin
            logic [1:0]  rq;
            bit          wr;
            int          d;
            logic [31:0] ia, ma, md;
            rq = 2'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            d  = int'($urandom_range(0, 2));
            ia = $urandom; ma = $urandom; md = $urandom;
            dma_ready = (d == 0);
            if_req = rq[0]; if_addr = ia;
            mem_req = rq[1]; mem_wr = wr; mem_addr = ma; mem_wdata = md;
            for (int j = 0; j < d; j++) begin
                step();
                chk32("rand_dma_hold", 32'(op), 32'h0);
            end
            dma_ready = 1'b1;
            if (rq[1]) run_xfer(1'b1, wr, ma, md, pick_k(t));
            if (rq[0]) run_xfer(1'b0, 1'b0, ia, 32'h0, pick_k(t + 100));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
